muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers. Sits in
//   the execute stage beside the ALU. hi/lo feed the write-back result mux4_32
//   (MFHI/MFLO paths). busy drives the pipeline stall logic.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; MTHI/MTLO write directly.
// Latency: WIDTH+2 edges from start to done (CALC x WIDTH, then FIX); MTHI/MTLO take effect at the start edge.
// Backpressure: busy=1 while an op is in flight; start is ignored while busy. MULDIV_FAST_MUL_EN gives single-cycle multiply.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t             state, state_nxt;
   logic               busy_nxt, done_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;        // mul: {partial product, remaining multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opnd;       // mul: |multiplicand|; div: |divisor|
   logic [WIDTH-1:0]   a_orig;     // raw dividend, returned in HI on divide-by-zero
   logic               is_div, sign_a, sign_b, div_zero;

   // Opcode decode and operand magnitudes (signed ops use op[0]=0)
   logic               op_mul, op_div, op_signed, op_mthi, op_mtlo, idle;
   logic               a_neg, b_neg, issue_iter, fast_mul;
   logic [WIDTH-1:0]   a_mag, b_mag;

   assign op_mul    = (op[2:1] == 2'b00);
   assign op_div    = (op[2:1] == 2'b01);
   assign op_signed = ~op[0];
   assign op_mthi   = (op == 3'b100);
   assign op_mtlo   = (op == 3'b101);
   assign idle      = (state == S_IDLE);
   assign a_neg     = op_signed & a[WIDTH-1];
   assign b_neg     = op_signed & b[WIDTH-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [WIDTH:0]     fast_a, fast_b;
   logic signed [2*WIDTH+1:0] fast_full;
   assign fast_a     = {op_signed & a[WIDTH-1], a};
   assign fast_b     = {op_signed & b[WIDTH-1], b};
   assign fast_full  = fast_a * fast_b;
   assign issue_iter = start & idle & op_div;
   assign fast_mul   = start & idle & op_mul;
`else
   assign issue_iter = start & idle & (op_mul | op_div);
   assign fast_mul   = 1'b0;
`endif

   // One iteration step: shift-add for multiply, restoring subtract for divide
   logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
   logic [2*WIDTH-1:0] acc_step;
   always_comb begin
      mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_rem_sh = acc[2*WIDTH-1:WIDTH-1];
      div_diff   = div_rem_sh - {1'b0, opnd};
      if (!is_div)
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      else if (div_diff[WIDTH])
         acc_step = {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // Sign fix-up of the magnitude result, plus the divide-by-zero override
   logic [WIDTH-1:0] fix_hi, fix_lo;
   always_comb begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
      if (!is_div) begin
         if (sign_a ^ sign_b)
            {fix_hi, fix_lo} = -acc;
      end else if (div_zero) begin
         fix_hi = a_orig;
         fix_lo = '1;
      end else begin
         if (sign_a ^ sign_b) fix_lo = -acc[WIDTH-1:0];
         if (sign_a)          fix_hi = -acc[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (issue_iter) state_nxt = S_CALC;
            done_nxt = fast_mul;
         end
         S_CALC: if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
         S_FIX: begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt != S_IDLE);
   end

   // State register and busy/done flops
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Datapath: operand latch, iteration, and HI/LO updates
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hi       <= '0;
         lo       <= '0;
         acc      <= '0;
         opnd     <= '0;
         a_orig   <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue_iter) begin
                  cnt      <= '0;
                  is_div   <= op_div;
                  sign_a   <= a_neg;
                  sign_b   <= b_neg;
                  div_zero <= (b == '0);
                  a_orig   <= a;
                  acc      <= op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                  opnd     <= op_div ? b_mag : a_mag;
`ifdef MULDIV_FAST_MUL_EN
               end else if (fast_mul) begin
                  {hi, lo} <= fast_full[2*WIDTH-1:0];
`endif
               end else if (start && op_mthi) begin
                  hi <= a;
               end else if (start && op_mtlo) begin
                  lo <= a;
               end
            end
            S_CALC: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
            end
            S_FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (default build, iterative multiply).
// Directed corner vectors plus randomized ops checked against a 64-bit arithmetic model.
module tb_muldiv_unit;

   localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
   localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, NOP = 3'b110;

   logic        clk, rstn, start, busy, done;
   logic [2:0]  op;
   logic [31:0] a, b, hi, lo;

   int n_vec = 0;
   int n_err = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: {hi, lo} from plain 64-bit arithmetic
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      res = 64'd0;
      case (o)
         MULT:  res = sx * sy;
         MULTU: res = {32'd0, x} * {32'd0, y};
         DIV:   if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
         DIVU:  if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   // Issue one op, scramble operands after the start edge, observe 40 cycles
   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int nbusy, output int ndone, output int done_at, output bit stable);
      logic [31:0] h0, l0;
      nbusy = 0; ndone = 0; done_at = -1; stable = 1'b1; rh = 'x; rl = 'x;
      @(negedge clk);
      h0 = hi; l0 = lo;
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      for (int i = 0; i < 40; i++) begin
         if (busy === 1'b1) begin
            nbusy++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
         end
         if (done === 1'b1) begin
            ndone++; done_at = i; rh = hi; rl = lo;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; start = 1'b0; op = MULT; a = '0; b = '0;
      repeat (3) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
      n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
      rstn = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] rh, rl; int nb, nd, dat; bit st;
      do_op(MULT, 32'hFFFF_FFFD, 32'd7, rh, rl, nb, nd, dat, st);
      n_vec++; if (rh !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", rh); end
      n_vec++; if (rl !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", rl); end
      n_vec++; if (nb != 33) begin n_err++; $display("FAIL mult_busy_cycles got %0d want 33", nb); end
      n_vec++; if (nd != 1) begin n_err++; $display("FAIL mult_done_cycles got %0d want 1", nd); end
      n_vec++; if (dat != 33) begin n_err++; $display("FAIL mult_done_latency got %0d want 33", dat); end
      n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL mult_hilo_stable got %0b want 1", st); end
      do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, nb, nd, dat, st);
      n_vec++; if (rh !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", rh); end
      n_vec++; if (rl !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", rl); end
   endtask

   task automatic test_div();
      logic [31:0] rh, rl; int nb, nd, dat; bit st;
      do_op(DIV, 32'hFFFF_FFF9, 32'd2, rh, rl, nb, nd, dat, st);
      n_vec++; if (rl !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", rl); end
      n_vec++; if (rh !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", rh); end
      n_vec++; if (nb != 33) begin n_err++; $display("FAIL div_busy_cycles got %0d want 33", nb); end
      do_op(DIVU, 32'd7, 32'd2, rh, rl, nb, nd, dat, st);
      n_vec++; if (rl !== 32'd3) begin n_err++; $display("FAIL divu_lo got %h want 3", rl); end
      n_vec++; if (rh !== 32'd1) begin n_err++; $display("FAIL divu_hi got %h want 1", rh); end
   endtask

   task automatic test_div_corners();
      logic [31:0] rh, rl; int nb, nd, dat; bit st;
      do_op(DIVU, 32'h0000_1234, 32'd0, rh, rl, nb, nd, dat, st);
      n_vec++; if (rl !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu0_lo got %h want ffffffff", rl); end
      n_vec++; if (rh !== 32'h0000_1234) begin n_err++; $display("FAIL divu0_hi got %h want 00001234", rh); end
      n_vec++; if (nd != 1) begin n_err++; $display("FAIL divu0_done got %0d want 1", nd); end
      do_op(DIV, 32'h8765_4321, 32'd0, rh, rl, nb, nd, dat, st);
      n_vec++; if (rl !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_lo got %h want ffffffff", rl); end
      n_vec++; if (rh !== 32'h8765_4321) begin n_err++; $display("FAIL div0_hi got %h want 87654321", rh); end
      do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, nb, nd, dat, st);
      n_vec++; if (rl !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo got %h want 80000000", rl); end
      n_vec++; if (rh !== 32'd0) begin n_err++; $display("FAIL divovf_hi got %h want 0", rh); end
   endtask

   task automatic test_start_while_busy();
      logic [31:0] x, y, rh, rl; logic [63:0] exp; int nd;
      x = $urandom; y = $urandom; exp = model(MULT, x, y); nd = 0; rh = 'x; rl = 'x;
      @(negedge clk); start = 1'b1; op = MULT; a = x; b = y;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; op = MTHI; a = 32'hA5A5_A5A5;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin nd++; rh = hi; rl = lo; end
         @(negedge clk);
      end
      n_vec++; if (rh !== exp[63:32]) begin n_err++; $display("FAIL busy_mthi_hi got %h want %h", rh, exp[63:32]); end
      n_vec++; if (rl !== exp[31:0]) begin n_err++; $display("FAIL busy_mthi_lo got %h want %h", rl, exp[31:0]); end
      n_vec++; if (nd != 1) begin n_err++; $display("FAIL busy_mthi_done got %0d want 1", nd); end
   endtask

   task automatic test_mt_idle();
      logic [31:0] old_lo, old_hi;
      old_lo = lo;
      @(negedge clk); start = 1'b1; op = MTHI; a = 32'hA5A5_A5A5;
      @(negedge clk); start = 1'b0;
      n_vec++; if (hi !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mthi_hi got %h want a5a5a5a5", hi); end
      n_vec++; if (lo !== old_lo) begin n_err++; $display("FAIL mthi_lo got %h want %h", lo, old_lo); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %0b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mthi_done got %0b want 0", done); end
      start = 1'b1; op = MTLO; a = 32'h3C3C_0FF0;
      @(negedge clk); start = 1'b0;
      n_vec++; if (lo !== 32'h3C3C_0FF0) begin n_err++; $display("FAIL mtlo_lo got %h want 3c3c0ff0", lo); end
      n_vec++; if (hi !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mtlo_hi got %h want a5a5a5a5", hi); end
      old_hi = hi; old_lo = lo;
      start = 1'b1; op = NOP; a = $urandom; b = $urandom;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      n_vec++; if ({hi, lo} !== {old_hi, old_lo}) begin n_err++; $display("FAIL nop_hilo got %h want %h", {hi, lo}, {old_hi, old_lo}); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nop_busy got %0b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int nd, nb;
      nd = 0; nb = 0;
      @(negedge clk); start = 1'b1; op = MTHI; a = 32'h1111_2222;
      @(negedge clk); start = 1'b1; op = DIV; a = $urandom; b = $urandom_range(1, 1000);
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %0b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %0b want 0", done); end
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL rstmid_hi got %h want 0", hi); end
      n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL rstmid_lo got %h want 0", lo); end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
         if (busy === 1'b1) nb++;
      end
      n_vec++; if (nd != 0) begin n_err++; $display("FAIL rstmid_late_done got %0d want 0", nd); end
      n_vec++; if (nb != 0) begin n_err++; $display("FAIL rstmid_late_busy got %0d want 0", nb); end
   endtask

   task automatic test_random();
      logic [31:0] x, y, rh, rl; logic [2:0] o; logic [63:0] exp;
      int nb, nd, dat, sel; bit st;
      for (int k = 0; k < 40; k++) begin
         o = 3'($urandom_range(0, 3)); x = $urandom; y = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) y = 32'd0;
         else if (sel == 1) y = 32'($urandom_range(1, 15));
         else if (sel == 2) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
         else if (sel == 3) x = 32'($urandom_range(0, 255));
         exp = model(o, x, y);
         do_op(o, x, y, rh, rl, nb, nd, dat, st);
         n_vec++; if ({rh, rl} !== exp) begin n_err++; $display("FAIL rand_%0d op=%0d a=%h b=%h got %h want %h", k, o, x, y, {rh, rl}, exp); end
         n_vec++; if (nb != 33 || nd != 1 || dat != 33) begin n_err++; $display("FAIL rand_timing_%0d busy=%0d done=%0d at=%0d want 33/1/33", k, nb, nd, dat); end
         n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL rand_stable_%0d got %0b want 1", k, st); end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_corners();
      test_start_while_busy();
      test_mt_idle();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
